// File: rtl/alu_shift_pkg.sv
// Shared types for the iterative shift unit: operation codes, FSM states, default width.
package alu_shift_pkg;

    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        SH_SLL  = 2'b00,
        SH_SRL  = 2'b01,
        SH_SRA  = 2'b10,
        SH_PASS = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/alu_shift_stage.sv
// One binary shifter stage: shifts by 2^i_idx when enabled, else passes data through.
// Latency: purely combinational.
// Backpressure: none; the controller decides when the result is captured.
module alu_shift_stage
    import alu_shift_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int SHAMT_W = $clog2(DATA_W)
) (
    input  logic [DATA_W-1:0]  i_data,
    input  shift_op_e          i_op,
    input  logic [SHAMT_W-1:0] i_idx,
    input  logic               i_en,
    output logic [DATA_W-1:0]  o_data
);

    logic [DATA_W-1:0] amt;

    always_comb begin
        amt        = '0;
        amt[i_idx] = 1'b1;
    end

    always_comb begin
        o_data = i_data;
        if (i_en) begin
            case (i_op)
                SH_SLL:  o_data = i_data << amt;
                SH_SRL:  o_data = i_data >> amt;
                SH_SRA:  o_data = $signed(i_data) >>> amt;
                default: o_data = i_data;
            endcase
        end
    end

endmodule

// File: rtl/alu_shift_seq.sv
// Iterative SLL/SRL/SRA unit walking one binary stage per clock through a shared stage.
// Latency: result valid the cycle after accept edge + SHAMT_W; every shift amount costs the same.
// Backpressure: o_valid/o_result held in DONE until i_ready; o_ready only in IDLE.
module alu_shift_seq
    import alu_shift_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int SHAMT_W = $clog2(DATA_W)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [1:0]        i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_result,
    output logic              o_busy
);

    localparam logic [SHAMT_W-1:0] LAST_CNT = SHAMT_W'(SHAMT_W - 1);

    state_e             state_q, state_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [SHAMT_W-1:0] shamt_q, shamt_d;
    shift_op_e          op_q, op_d;
    logic [DATA_W-1:0]  stage_out;

    alu_shift_stage #(
        .DATA_W  (DATA_W),
        .SHAMT_W (SHAMT_W)
    ) u_stage (
        .i_data (data_q),
        .i_op   (op_q),
        .i_idx  (cnt_q),
        .i_en   (shamt_q[cnt_q]),
        .o_data (stage_out)
    );

    // Flush wins over every handshake; operand registers are deliberately left as-is.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        shamt_d = shamt_q;
        op_d    = op_q;
        if (i_flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_valid) begin
                        data_d  = i_a;
                        shamt_d = i_b[SHAMT_W-1:0];
                        op_d    = shift_op_e'(i_op);
                        cnt_d   = '0;
                        state_d = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    data_d = stage_out;
                    cnt_d  = cnt_q + SHAMT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (i_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            shamt_q <= '0;
            op_q    <= SH_SLL;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            shamt_q <= shamt_d;
            op_q    <= op_d;
        end
    end

    assign o_ready  = (state_q == ST_IDLE);
    assign o_valid  = (state_q == ST_DONE);
    assign o_busy   = (state_q == ST_SHIFT) || (state_q == ST_DONE);
    assign o_result = data_q;

endmodule
